// File: rtl/pp_row_reducer_pkg.sv
// rtl/pp_row_reducer_pkg.sv - shared FMA widths and lane-product type
package pp_row_reducer_pkg;

  // Row multiplexer stage: 11b mantissas, partial products pre-shifted by 3 per slice
  localparam int MANT_W   = 11;
  localparam int PP_SHIFT = 3;

  localparam int LANES  = 16;
  localparam int NPP    = 4;
  localparam int PP_W   = 24;
  localparam int PROD_W = 22;
  localparam int ROW_W  = 4;

  typedef struct packed {
    logic [PROD_W-1:0] prod;
    logic              norm;
  } lane_prod_t;

endpackage

// File: rtl/pp_row_reducer_lane_sum.sv
// rtl/pp_row_reducer_lane_sum.sv - per-lane partial-product adder, split at the S1 boundary
module pp_lane_sum
  import pp_row_reducer_pkg::*;
(
  input  logic [NPP*PP_W-1:0] pp_i,
  output logic [PP_W-1:0]     pair_lo_o,
  output logic [PP_W-1:0]     pair_hi_o,
  input  logic [PP_W-1:0]     pair_lo_i,
  input  logic [PP_W-1:0]     pair_hi_i,
  output lane_prod_t          res_o,
  output logic                err_o
);

  logic [PP_W-1:0] sum;

  always_comb begin
    pair_lo_o = '0;
    pair_hi_o = '0;
    for (int k = 0; k < NPP; k++) begin
      if (k < NPP / 2) pair_lo_o = pair_lo_o + pp_i[k*PP_W +: PP_W];
      else             pair_hi_o = pair_hi_o + pp_i[k*PP_W +: PP_W];
    end
  end

  // Modulo-2^PP_W sum; any bit above the product width means the lane left range
  assign sum        = pair_lo_i + pair_hi_i;
  assign res_o.prod = sum[PROD_W-1:0];
  assign res_o.norm = sum[PROD_W-1];
  assign err_o      = |sum[PP_W-1:PROD_W];

endmodule

// File: rtl/pp_row_reducer.sv
// rtl/pp_row_reducer.sv - 2-stage partial-product row reducer with row tagging
module pp_row_reducer #(
  parameter int LANES  = pp_row_reducer_pkg::LANES,
  parameter int NPP    = pp_row_reducer_pkg::NPP,
  parameter int PP_W   = pp_row_reducer_pkg::PP_W,
  parameter int PROD_W = pp_row_reducer_pkg::PROD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*NPP*PP_W-1:0] in_pp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*PROD_W-1:0]  out_prod,
  output logic [LANES-1:0]         out_norm,
  output logic [3:0]               out_row,
  output logic                     out_last,
  output logic                     err_sticky
);
  import pp_row_reducer_pkg::*;

  logic                    s1_valid_q, s2_valid_q;
  logic [ROW_W-1:0]        row_cnt_q, s1_row_q, s2_row_q;
  logic [LANES*PP_W-1:0]   s1_lo_q, s1_hi_q, lo_d, hi_d;
  logic [LANES*PROD_W-1:0] s2_prod_q, prod_d;
  logic [LANES-1:0]        s2_norm_q, norm_d, err_d;
  logic                    err_sticky_q;
  logic                    s2_free, s1_adv, accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_prod_t res;

    pp_lane_sum u_sum (
      .pp_i      (in_pp[g*NPP*PP_W +: NPP*PP_W]),
      .pair_lo_o (lo_d[g*PP_W +: PP_W]),
      .pair_hi_o (hi_d[g*PP_W +: PP_W]),
      .pair_lo_i (s1_lo_q[g*PP_W +: PP_W]),
      .pair_hi_i (s1_hi_q[g*PP_W +: PP_W]),
      .res_o     (res),
      .err_o     (err_d[g])
    );

    assign prod_d[g*PROD_W +: PROD_W] = res.prod;
    assign norm_d[g]                  = res.norm;
  end

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !clr && (!s1_valid_q || s1_adv);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      row_cnt_q    <= '0;
      s1_row_q     <= '0;
      s2_row_q     <= '0;
      s1_lo_q      <= '0;
      s1_hi_q      <= '0;
      s2_prod_q    <= '0;
      s2_norm_q    <= '0;
      err_sticky_q <= 1'b0;
    end else if (clr) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      row_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      if (!s1_valid_q || s1_adv) s1_valid_q <= in_valid;
      if (accept) begin
        s1_lo_q   <= lo_d;
        s1_hi_q   <= hi_d;
        s1_row_q  <= row_cnt_q;
        row_cnt_q <= row_cnt_q + 4'd1;
      end
      if (s2_free) s2_valid_q <= s1_valid_q;
      // Data only moves on a real transfer so a stalled output stays frozen
      if (s1_adv) begin
        s2_prod_q <= prod_d;
        s2_norm_q <= norm_d;
        s2_row_q  <= s1_row_q;
        if (|err_d) err_sticky_q <= 1'b1;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_prod   = s2_prod_q;
  assign out_norm   = s2_norm_q;
  assign out_row    = s2_row_q;
  assign out_last   = (s2_row_q == 4'd15);
  assign err_sticky = err_sticky_q;

endmodule
